// File: rtl/fifo_arbiter.sv
// Two-producer round-robin write arbiter in front of a FIFO,
// with occupancy tracking, consumer read grants and a drain (flush) mode.
module fifo_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_WIDTH  = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic [DATA_WIDTH-1:0] data0,
  input  logic [DATA_WIDTH-1:0] data1,
  output logic                  gnt0,
  output logic                  gnt1,
  input  logic                  rd_req,
  output logic                  rd_gnt,
  input  logic                  flush,
  output logic                  flush_done,
  output logic                  fifo_write_n,
  output logic                  fifo_read_n,
  output logic [DATA_WIDTH-1:0] fifo_data,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  full,
  output logic                  empty
);

  localparam logic [CNT_WIDTH-1:0] DEPTH = CNT_WIDTH'(FIFO_DEPTH);
  localparam logic [CNT_WIDTH-1:0] ONE   = CNT_WIDTH'(1);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t                state_q, state_d;
  logic                  gnt0_q, gnt0_d;
  logic                  gnt1_q, gnt1_d;
  logic                  rd_gnt_q, rd_gnt_d;
  logic                  done_q, done_d;
  logic                  wr_n_q, wr_n_d;
  logic                  rd_n_q, rd_n_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  full_q, empty_q;
  // prio_q=1 means producer 1 wins a tie (producer 0 was granted last)
  logic                  prio_q, prio_d;

  logic rd_ok, wr_ok, pick1;

  assign rd_ok = rd_req && (count_q != '0);
  assign wr_ok = (req0 || req1) && ((count_q != DEPTH) || rd_ok);
  assign pick1 = req1 && (!req0 || prio_q);

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  // Next-state: flush enters drain, drain ends once empty
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:   if (flush) state_d = FLUSH;
      FLUSH: if (count_q == '0) state_d = RUN;
    endcase
  end

  // Per-edge decision: grants, strobes, count and pointer update
  always_comb begin
    gnt0_d   = 1'b0;
    gnt1_d   = 1'b0;
    rd_gnt_d = 1'b0;
    done_d   = 1'b0;
    wr_n_d   = 1'b1;
    rd_n_d   = 1'b1;
    data_d   = data_q;
    count_d  = count_q;
    prio_d   = prio_q;
    unique case (state_q)
      RUN: begin
        if (!flush) begin
          if (rd_ok) begin
            rd_gnt_d = 1'b1;
            rd_n_d   = 1'b0;
          end
          if (wr_ok) begin
            wr_n_d = 1'b0;
            if (pick1) begin
              gnt1_d = 1'b1;
              data_d = data1;
              prio_d = 1'b0;
            end else begin
              gnt0_d = 1'b1;
              data_d = data0;
              prio_d = 1'b1;
            end
          end
          if (wr_ok && !rd_ok)      count_d = count_q + ONE;
          else if (rd_ok && !wr_ok) count_d = count_q - ONE;
        end
      end
      FLUSH: begin
        if (count_q != '0) begin
          rd_n_d  = 1'b0;
          count_d = count_q - ONE;
        end else begin
          done_d = 1'b1;
        end
      end
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      rd_gnt_q <= 1'b0;
      done_q   <= 1'b0;
      wr_n_q   <= 1'b1;
      rd_n_q   <= 1'b1;
      data_q   <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      prio_q   <= 1'b0;
    end else begin
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      rd_gnt_q <= rd_gnt_d;
      done_q   <= done_d;
      wr_n_q   <= wr_n_d;
      rd_n_q   <= rd_n_d;
      data_q   <= data_d;
      count_q  <= count_d;
      full_q   <= (count_d == DEPTH);
      empty_q  <= (count_d == '0);
      prio_q   <= prio_d;
    end
  end

  assign gnt0         = gnt0_q;
  assign gnt1         = gnt1_q;
  assign rd_gnt       = rd_gnt_q;
  assign flush_done   = done_q;
  assign fifo_write_n = wr_n_q;
  assign fifo_read_n  = rd_n_q;
  assign fifo_data    = data_q;
  assign count        = count_q;
  assign full         = full_q;
  assign empty        = empty_q;

endmodule

// File: tb/tb_fifo_arbiter.sv
// Self-checking bench for fifo_arbiter: directed scenarios plus
// randomized traffic against a queue-based reference model.
module tb_fifo_arbiter;

  localparam int DW = 8;
  localparam int DEPTH = 16;
  localparam int CW = 5;

  logic          clock = 1'b0;
  logic          reset;
  logic          req0, req1, rd_req, flush;
  logic [DW-1:0] data0, data1;
  logic          gnt0, gnt1, rd_gnt, flush_done;
  logic          fifo_write_n, fifo_read_n;
  logic [DW-1:0] fifo_data;
  logic [CW-1:0] count;
  logic          full, empty;

  always #5 clock = ~clock;

  fifo_arbiter #(
    .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)
  ) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1),
    .data0(data0), .data1(data1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rd_req(rd_req), .rd_gnt(rd_gnt),
    .flush(flush), .flush_done(flush_done),
    .fifo_write_n(fifo_write_n), .fifo_read_n(fifo_read_n),
    .fifo_data(fifo_data), .count(count),
    .full(full), .empty(empty)
  );

  // {gnt0,gnt1,rd_gnt,flush_done,wr_n,rd_n,data,count,full,empty}
  logic [20:0] obs;
  assign obs = {gnt0, gnt1, rd_gnt, flush_done, fifo_write_n,
                fifo_read_n, fifo_data, count, full, empty};

  localparam logic [20:0] RST_V = {6'b000011, 8'h00, 5'd0, 1'b0, 1'b1};

  int nvec = 0;
  int nmis = 0;

  // Reference model: FIFO contents as a queue, drain flag, last winner
  logic [DW-1:0] mq[$];
  bit            m_flush;
  int            m_last;
  logic [DW-1:0] m_data;
  logic [20:0]   exp_v;

  function automatic logic [20:0] pack(bit g0, bit g1, bit rg, bit fd,
                                       bit wn, bit rn, logic [DW-1:0] d,
                                       int n);
    return {g0, g1, rg, fd, wn, rn, d, CW'(n), n == DEPTH, n == 0};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_flush = 0;
    m_last  = 1;
    m_data  = '0;
    exp_v   = RST_V;
  endtask

  // Advance one edge; model sees the inputs that were present at the edge
  task automatic tick();
    bit g0, g1, rg, fd, wn, rn, rd, wr;
    int who;
    @(posedge clock);
    g0 = 0; g1 = 0; rg = 0; fd = 0; wn = 1; rn = 1;
    if (!m_flush) begin
      if (flush) m_flush = 1;
      else begin
        rd = rd_req && mq.size() > 0;
        wr = (req0 || req1) && (mq.size() < DEPTH || rd);
        if (rd) begin
          void'(mq.pop_front());
          rg = 1; rn = 0;
        end
        if (wr) begin
          who = (req0 && req1) ? 1 - m_last : (req1 ? 1 : 0);
          m_last = who;
          m_data = who ? data1 : data0;
          mq.push_back(m_data);
          wn = 0; g0 = (who == 0); g1 = (who == 1);
        end
      end
    end else if (mq.size() > 0) begin
      void'(mq.pop_front());
      rn = 0;
    end else begin
      fd = 1;
      m_flush = 0;
    end
    exp_v = pack(g0, g1, rg, fd, wn, rn, m_data, mq.size());
    #1;
  endtask

  task automatic idle_inputs();
    req0 = 0; req1 = 0; rd_req = 0; flush = 0;
    data0 = '0; data1 = '0;
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset = 1;
    idle_inputs();
    @(negedge clock);
    reset = 0;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 1;
    idle_inputs();
    #3;
    nvec++;
    if (obs !== RST_V) begin
      nmis++;
      $display("FAIL reset_async got=%h want=%h", obs, RST_V);
    end
    req0 = 1; req1 = 1; rd_req = 1;
    @(posedge clock); #1;
    nvec++;
    if (obs !== RST_V) begin
      nmis++;
      $display("FAIL reset_held got=%h want=%h", obs, RST_V);
    end
    apply_reset();
  endtask

  task automatic test_alternate();
    apply_reset();
    req0 = 1; req1 = 1; data0 = 8'hA0; data1 = 8'hB1;
    for (int i = 0; i < 4; i++) begin
      tick();
      nvec++;
      if (gnt0 !== (i % 2 == 0) || gnt1 !== (i % 2 == 1) ||
          fifo_data !== ((i % 2) ? 8'hB1 : 8'hA0)) begin
        nmis++;
        $display("FAIL alt_grant i=%0d got g0=%b g1=%b d=%h", i,
                 gnt0, gnt1, fifo_data);
      end
      nvec++;
      if (obs !== exp_v) begin
        nmis++;
        $display("FAIL alt_model got=%h want=%h", obs, exp_v);
      end
    end
    nvec++;
    if (count !== 5'd4) begin
      nmis++;
      $display("FAIL alt_count got=%0d want=4", count);
    end
    idle_inputs();
  endtask

  task automatic test_full();
    apply_reset();
    req0 = 1;
    for (int i = 0; i < 15; i++) begin
      data0 = DW'($urandom);
      tick();
      nvec++;
      if (obs !== exp_v) begin
        nmis++;
        $display("FAIL fill_model got=%h want=%h", obs, exp_v);
      end
    end
    tick();
    nvec++;
    if (gnt0 !== 1'b1 || full !== 1'b1 || count !== 5'd16) begin
      nmis++;
      $display("FAIL full_last got g0=%b full=%b cnt=%0d want 1 1 16",
               gnt0, full, count);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      nvec++;
      if (gnt0 !== 1'b0 || fifo_write_n !== 1'b1 || count !== 5'd16) begin
        nmis++;
        $display("FAIL full_block got g0=%b wn=%b cnt=%0d want 0 1 16",
                 gnt0, fifo_write_n, count);
      end
    end
    req0 = 0; req1 = 1; rd_req = 1; data1 = 8'h5C;
    tick();
    nvec++;
    if (gnt1 !== 1'b1 || rd_gnt !== 1'b1 || count !== 5'd16) begin
      nmis++;
      $display("FAIL full_rw got g1=%b rg=%b cnt=%0d want 1 1 16",
               gnt1, rd_gnt, count);
    end
    nvec++;
    if (obs !== exp_v) begin
      nmis++;
      $display("FAIL full_rw_model got=%h want=%h", obs, exp_v);
    end
    idle_inputs();
  endtask

  task automatic test_empty_read();
    apply_reset();
    rd_req = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      nvec++;
      if (rd_gnt !== 1'b0 || fifo_read_n !== 1'b1 || count !== 5'd0) begin
        nmis++;
        $display("FAIL empty_read got rg=%b rn=%b cnt=%0d want 0 1 0",
                 rd_gnt, fifo_read_n, count);
      end
    end
    idle_inputs();
  endtask

  task automatic test_flush();
    int rn_cnt, fd_cnt;
    apply_reset();
    req0 = 1;
    for (int i = 0; i < 3; i++) begin
      data0 = DW'($urandom);
      tick();
    end
    flush = 1;
    tick();
    flush = 0;
    nvec++;
    if (gnt0 !== 1'b0 || fifo_write_n !== 1'b1 || count !== 5'd3) begin
      nmis++;
      $display("FAIL flush_entry got g0=%b wn=%b cnt=%0d want 0 1 3",
               gnt0, fifo_write_n, count);
    end
    rn_cnt = 0; fd_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      flush = (i == 1);
      tick();
      if (!fifo_read_n) rn_cnt++;
      if (flush_done) fd_cnt++;
      nvec++;
      if (obs !== exp_v) begin
        nmis++;
        $display("FAIL flush_model i=%0d got=%h want=%h", i, obs, exp_v);
      end
    end
    flush = 0;
    nvec++;
    if (rn_cnt != 3 || fd_cnt != 1 || count !== 5'd0) begin
      nmis++;
      $display("FAIL flush_drain got rd=%0d done=%0d cnt=%0d want 3 1 0",
               rn_cnt, fd_cnt, count);
    end
    req0 = 0;
    tick();
    req0 = 1; req1 = 1;
    tick();
    nvec++;
    if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin
      nmis++;
      $display("FAIL flush_rr got g0=%b g1=%b want 0 1", gnt0, gnt1);
    end
    idle_inputs();
  endtask

  task automatic test_flush_empty();
    apply_reset();
    flush = 1;
    tick();
    flush = 0;
    tick();
    nvec++;
    if (flush_done !== 1'b1 || fifo_read_n !== 1'b1) begin
      nmis++;
      $display("FAIL flush_empty got fd=%b rn=%b want 1 1",
               flush_done, fifo_read_n);
    end
    tick();
    nvec++;
    if (flush_done !== 1'b0) begin
      nmis++;
      $display("FAIL flush_empty_pulse got fd=%b want 0", flush_done);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    req1 = 1;
    for (int i = 0; i < 4; i++) begin
      data1 = DW'($urandom);
      tick();
    end
    req1 = 0;
    flush = 1;
    tick();
    flush = 0;
    tick();
    tick();
    nvec++;
    if (count !== 5'd2 || fifo_read_n !== 1'b0) begin
      nmis++;
      $display("FAIL arst_setup got cnt=%0d rn=%b want 2 0",
               count, fifo_read_n);
    end
    #2;
    reset = 1;
    #1;
    nvec++;
    if (count !== 5'd0 || fifo_read_n !== 1'b1 || empty !== 1'b1) begin
      nmis++;
      $display("FAIL arst_now got cnt=%0d rn=%b e=%b want 0 1 1",
               count, fifo_read_n, empty);
    end
    @(negedge clock);
    reset = 0;
    model_reset();
    req0 = 1; req1 = 1;
    tick();
    nvec++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
      nmis++;
      $display("FAIL arst_prio got g0=%b g1=%b want 1 0", gnt0, gnt1);
    end
    idle_inputs();
  endtask

  task automatic test_random();
    int wp, rp;
    apply_reset();
    for (int i = 0; i < 800; i++) begin
      wp = ((i / 100) % 2) ? 30 : 85;
      rp = ((i / 100) % 2) ? 80 : 25;
      req0   = ($urandom_range(99) < wp);
      req1   = ($urandom_range(99) < wp);
      rd_req = ($urandom_range(99) < rp);
      flush  = ($urandom_range(63) == 0);
      data0  = DW'($urandom);
      data1  = DW'($urandom);
      tick();
      nvec++;
      if (obs !== exp_v) begin
        nmis++;
        $display("FAIL random i=%0d got=%h want=%h", i, obs, exp_v);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_alternate();
    test_full();
    test_empty_read();
    test_flush();
    test_flush_empty();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
